// File: rtl/wave_generator_pkg.sv
// Shared constants and helpers for the wave_generator DDS sine source.
// The quarter-wave table is built at elaboration by lut_entry().
package wave_generator_pkg;

  localparam int PHASE_W    = 32;
  localparam int SAMPLE_W   = 16;
  localparam int LUT_W      = 15;
  localparam int LUT_AW_DEF = 8;

  // pi in Q60 fixed point (hex digits of pi, truncated)
  localparam logic [63:0] PI_Q60 = 64'h3243_F6A8_885A_308D;

  // round(32767 * sin(pi/2 * (idx + 0.5) / 2^aw)) via a Q60 Taylor series
  function automatic logic [LUT_W-1:0] lut_entry(input int unsigned idx, input int unsigned aw);
    logic signed [127:0] x;
    logic signed [127:0] x2;
    logic signed [127:0] term;
    logic signed [127:0] sum;
    logic signed [127:0] div;
    logic signed [127:0] r;
    x    = $signed(128'(PI_Q60) * 128'(2 * idx + 1)) >>> (aw + 2);
    x2   = (x * x) >>> 60;
    term = x;
    sum  = x;
    for (int k = 1; k <= 12; k++) begin
      div  = 128'(2 * k * (2 * k + 1));
      term = -(((term * x2) >>> 60) / div);
      sum  = sum + term;
    end
    r = (sum * 128'sd32767 + (128'sd1 <<< 59)) >>> 60;
    return r[LUT_W-1:0];
  endfunction

  // Two's-complement signed sample from a sign flag and a 15-bit magnitude.
  function automatic logic [SAMPLE_W-1:0] apply_sign(input logic neg, input logic [LUT_W-1:0] mag);
    logic [SAMPLE_W-1:0] m;
    m = {1'b0, mag};
    return neg ? (~m + 16'd1) : m;
  endfunction

endpackage

// File: rtl/wave_generator_sine_lut.sv
// Registered-read quarter-wave sine ROM; contents are elaboration-time constants.
module wave_generator_sine_lut
  import wave_generator_pkg::*;
#(
  parameter int LUT_AW = LUT_AW_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [LUT_AW-1:0] addr_i,
  output logic [LUT_W-1:0]  data_o
);

  localparam int N = 1 << LUT_AW;

  logic [LUT_W-1:0] rom_s [N];
  logic [LUT_W-1:0] data_q;

  for (genvar g = 0; g < N; g++) begin : g_rom
    localparam logic [LUT_W-1:0] ENTRY = lut_entry(g, LUT_AW);
    assign rom_s[g] = ENTRY;
  end

  always_ff @(posedge clk) begin
    if (reset) data_q <= '0;
    else       data_q <= rom_s[addr_i];
  end

  assign data_o = data_q;

endmodule

// File: rtl/wave_generator.sv
// DDS sine source: phase accumulator, quadrant fold, ROM read, sign stage.
// Define WAVE_GENERATOR_COS_EN to also emit a cosine sample on tdata[31:16].
module wave_generator
  import wave_generator_pkg::*;
#(
  parameter logic [PHASE_W-1:0] PHASE_INC = 32'h0100_0000,
  parameter int                 LUT_AW    = LUT_AW_DEF
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] m_axis_data_tdata
);

  logic [PHASE_W-1:0]  acc_q, acc_d;
  logic [LUT_AW+1:0]   addr_s;
  logic [1:0]          quad_s;
  logic [LUT_AW-1:0]   idx_s;
  logic [1:0]          quad1_q, quad2_q;
  logic [LUT_AW-1:0]   idx1_q;
  logic                vld1_q, vld2_q;
  logic [LUT_W-1:0]    sin_mag_s;
  logic [SAMPLE_W-1:0] sin_d, sin_q;
  logic [SAMPLE_W-1:0] upper_s;

  assign acc_d  = acc_q + PHASE_INC;
  assign addr_s = acc_q[PHASE_W-1 -: LUT_AW+2];
  assign quad_s = addr_s[LUT_AW+1:LUT_AW];
  assign idx_s  = addr_s[LUT_AW-1:0];

  // Valid bits keep the output at zero until real samples reach stage 3.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q   <= '0;
      quad1_q <= '0;
      idx1_q  <= '0;
      vld1_q  <= 1'b0;
      quad2_q <= '0;
      vld2_q  <= 1'b0;
      sin_q   <= '0;
    end else begin
      acc_q   <= acc_d;
      quad1_q <= quad_s;
      idx1_q  <= quad_s[0] ? ~idx_s : idx_s;
      vld1_q  <= 1'b1;
      quad2_q <= quad1_q;
      vld2_q  <= vld1_q;
      sin_q   <= sin_d;
    end
  end

  wave_generator_sine_lut #(.LUT_AW(LUT_AW)) u_sin_lut (
    .clk    (clk),
    .reset  (reset),
    .addr_i (idx1_q),
    .data_o (sin_mag_s)
  );

  assign sin_d = vld2_q ? apply_sign(quad2_q[1], sin_mag_s) : '0;

`ifdef WAVE_GENERATOR_COS_EN
  logic [1:0]          cquad_s;
  logic [1:0]          cquad1_q, cquad2_q;
  logic [LUT_AW-1:0]   cidx1_q;
  logic [LUT_W-1:0]    cos_mag_s;
  logic [SAMPLE_W-1:0] cos_d, cos_q;

  // Cosine is the sine lookup one quadrant ahead.
  assign cquad_s = quad_s + 2'd1;

  always_ff @(posedge clk) begin
    if (reset) begin
      cquad1_q <= '0;
      cidx1_q  <= '0;
      cquad2_q <= '0;
      cos_q    <= '0;
    end else begin
      cquad1_q <= cquad_s;
      cidx1_q  <= cquad_s[0] ? ~idx_s : idx_s;
      cquad2_q <= cquad1_q;
      cos_q    <= cos_d;
    end
  end

  wave_generator_sine_lut #(.LUT_AW(LUT_AW)) u_cos_lut (
    .clk    (clk),
    .reset  (reset),
    .addr_i (cidx1_q),
    .data_o (cos_mag_s)
  );

  assign cos_d   = vld2_q ? apply_sign(cquad2_q[1], cos_mag_s) : '0;
  assign upper_s = cos_q;
`else
  assign upper_s = 16'h0000;
`endif

  assign m_axis_data_tdata = {upper_s, sin_q};

endmodule

// File: tb/tb_wave_generator.sv
// Directed self-checking bench for wave_generator (default and negative-step instances).
module tb_wave_generator;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] tdata;
  logic [31:0] tdata_neg;

  int n_vec = 0;
  int n_err = 0;
  int edge_n = 0;
  int samp [0:300];
  int nsamp [0:300];

  always #4 clk = ~clk;

  wave_generator dut (
    .clk               (clk),
    .reset             (reset),
    .m_axis_data_tdata (tdata)
  );

  wave_generator #(.PHASE_INC(32'hFF00_0000)) dut_neg (
    .clk               (clk),
    .reset             (reset),
    .m_axis_data_tdata (tdata_neg)
  );

  task automatic check_vec(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @edge %0d: got %0d expected %0d", tag, edge_n, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    edge_n++;
  endtask

  function automatic int lo_of(input logic [31:0] d);
    return int'($signed(d[15:0]));
  endfunction

  function automatic int hi_of(input logic [31:0] d);
    return int'($signed(d[31:16]));
  endfunction

  initial begin
    int s;
    int sum_a = 0;
    int sum_b = 0;
    int mx = -100000;
    int mn = 100000;

    repeat (3) tick();
    check_vec("reset_tdata", int'(tdata), 0);
    check_vec("reset_tdata_neg", int'(tdata_neg), 0);

    reset  = 1'b0;
    edge_n = 0;
    for (int e = 1; e <= 300; e++) begin
      tick();
      s = lo_of(tdata);
      samp[e]  = s;
      nsamp[e] = lo_of(tdata_neg);
      if (e <= 2) begin
        check_vec("release_zero", int'(tdata), 0);
        check_vec("release_zero_neg", int'(tdata_neg), 0);
      end
      case (e)
        3:   check_vec("sin_e3", s, 101);
        4:   check_vec("sin_e4", s, 905);
        67:  check_vec("sin_e67", s, 32767);
        131: check_vec("sin_e131", s, -101);
        195: check_vec("sin_e195", s, -32767);
        259: check_vec("sin_e259", s, 101);
        default: ;
      endcase
      case (e)
        3: check_vec("neg_e3", nsamp[e], 101);
        4: check_vec("neg_e4", nsamp[e], -704);
        5: check_vec("neg_e5", nsamp[e], -1507);
        default: ;
      endcase
      if (e >= 259) begin
        check_vec("period", s, samp[e-256]);
        check_vec("period_neg", nsamp[e], nsamp[e-256]);
      end
      if (e >= 3 && e <= 258) begin
        sum_a += s;
        if (s > mx) mx = s;
        if (s < mn) mn = s;
      end
      if (e >= 40 && e <= 295) sum_b += s;
`ifdef WAVE_GENERATOR_COS_EN
      if (e == 3)   check_vec("cos_e3", hi_of(tdata), 32767);
      if (e == 131) check_vec("cos_e131", hi_of(tdata), -32767);
`else
      check_vec("upper_zero", hi_of(tdata), 0);
`endif
    end
    check_vec("sum_period_a", sum_a, 0);
    check_vec("sum_period_b", sum_b, 0);
    check_vec("max", mx, 32767);
    check_vec("min", mn, -32767);

    // one-cycle reset pulse mid-run, then the release sequence must replay
    reset = 1'b1;
    tick();
    check_vec("pulse_clear", int'(tdata), 0);
    check_vec("pulse_clear_neg", int'(tdata_neg), 0);
    reset  = 1'b0;
    edge_n = 0;
    tick();
    check_vec("replay_e1", int'(tdata), 0);
    tick();
    check_vec("replay_e2", int'(tdata), 0);
    tick();
    check_vec("replay_e3", lo_of(tdata), 101);
    check_vec("replay_neg_e3", lo_of(tdata_neg), 101);
    tick();
    check_vec("replay_e4", lo_of(tdata), 905);
    check_vec("replay_neg_e4", lo_of(tdata_neg), -704);
    repeat (63) tick();
    check_vec("replay_e67", lo_of(tdata), 32767);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
